// File: rtl/top_module_reduce_and.sv
// top_module_reduce_and: eight-input AND-reduction with Port_Num-stage registered output.
// Define TOP_MODULE_HIT_MASK_EN to add the per-input all-ones hit_mask output.
module top_module_reduce_and #(
    parameter int Port_Num = 2,
    parameter int WIDTH    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] f,
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] h,
    output logic [WIDTH-1:0] q
`ifdef TOP_MODULE_HIT_MASK_EN
    ,
    output logic [7:0]       hit_mask
`endif
);
`ifdef TOP_MODULE_HIT_MASK_EN
    localparam int SW = 9;
`else
    localparam int SW = 1;
`endif
    logic [7:0]    m;
    logic          r;
    logic [SW-1:0] s;
    logic [SW-1:0] o;

    assign m = {&h, &g, &f, &e, &d, &c, &b, &a};
    assign r = &m;
`ifdef TOP_MODULE_HIT_MASK_EN
    // bit 0 carries the result, bits 8:1 the mask, so both share one pipeline
    assign s = {m, r};
    assign hit_mask = o[8:1];
`else
    assign s = r;
`endif
    assign q = WIDTH'(o[0]);

    if (Port_Num == 0) begin : g_comb
        assign o = s;
    end else begin : g_pipe
        logic [SW-1:0] st [Port_Num];
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < Port_Num; i++) st[i] <= '0;
            end else begin
                st[0] <= s;
                for (int i = 1; i < Port_Num; i++) st[i] <= st[i-1];
            end
        end
        assign o = st[Port_Num-1];
    end
endmodule

// File: tb/tb_top_module_reduce_and.sv
// tb_top_module_reduce_and: randomized self-checking bench with a per-edge history reference model.
module tb_top_module_reduce_and;
    localparam int P = 2;
    localparam int N = 512;

    logic       clk = 0;
    logic       rst = 1;
    logic [7:0] in [8];
    logic [7:0] q;
    logic [3:0] cin [8];
    logic [3:0] cq;
`ifdef TOP_MODULE_HIT_MASK_EN
    logic [7:0] hm;
    logic [7:0] chm;
`endif

    int checks = 0;
    int errors = 0;
    int n = 0;
    bit         hr [N];
    bit         hres [N];
    logic [7:0] hmask [N];

    always #5 clk = ~clk;

    top_module_reduce_and #(.Port_Num(P), .WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .a(in[0]), .b(in[1]), .c(in[2]), .d(in[3]),
        .e(in[4]), .f(in[5]), .g(in[6]), .h(in[7]),
        .q(q)
`ifdef TOP_MODULE_HIT_MASK_EN
        , .hit_mask(hm)
`endif
    );

    top_module_reduce_and #(.Port_Num(0), .WIDTH(4)) dut_comb (
        .clk(clk), .rst(rst),
        .a(cin[0]), .b(cin[1]), .c(cin[2]), .d(cin[3]),
        .e(cin[4]), .f(cin[5]), .g(cin[6]), .h(cin[7]),
        .q(cq)
`ifdef TOP_MODULE_HIT_MASK_EN
        , .hit_mask(chm)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // output after edge k is 0 if any reset fell in the last P edges, else the inputs seen P-1 edges ago
    function automatic bit flushed(input int k);
        for (int j = k - P + 1; j <= k; j++)
            if (j < 0 || hr[j]) return 1;
        return 0;
    endfunction

    task automatic set_all(input logic [7:0] v);
        for (int i = 0; i < 8; i++) in[i] = v;
    endtask

    task automatic tick(input string tag);
        logic [7:0] mk;
        @(posedge clk);
        mk = '0;
        for (int i = 0; i < 8; i++) mk[i] = (in[i] == 8'hFF);
        hr[n] = rst;
        hres[n] = (mk == 8'hFF);
        hmask[n] = mk;
        #1;
        chk(tag, q, flushed(n) ? 8'h00 : {7'b0, hres[n-P+1]});
`ifdef TOP_MODULE_HIT_MASK_EN
        chk({tag, "_mask"}, hm, flushed(n) ? 8'h00 : hmask[n-P+1]);
`endif
        n++;
    endtask

    initial begin
        set_all(8'hFF);
        for (int i = 0; i < 8; i++) cin[i] = 4'hF;
        rst = 1;
        tick("rst0");
        tick("rst1");
        rst = 0;
        tick("post_rst1");
        tick("post_rst2");
        chk("first_one", q, 8'h01);

        for (int k = 0; k < 3; k++) begin
            set_all(8'hFF);
            if (k == 0) in[7] = 8'hFE;
            if (k == 1) in[0] = 8'h7F;
            if (k == 2) in[3] = 8'hEF;
            tick("one_zero_bit");
            set_all(8'hFF);
            tick("one_zero_bit");
        end
        tick("one_zero_bit");
        tick("one_zero_bit");

        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < 8; i++) in[i] = 8'($urandom_range(0, 127));
            tick("rand_msb_clear");
        end

        for (int k = 0; k < 8; k++) begin
            set_all(k[0] ? 8'h00 : 8'hFF);
            tick("alternate");
        end

        set_all(8'hFF);
        tick("mid_rst_a");
        rst = 1;
        tick("mid_rst_b");
        rst = 0;
        tick("mid_rst_c");
        chk("inflight_dropped", q, 8'h00);
        tick("mid_rst_d");
        chk("back_to_one", q, 8'h01);

        for (int k = 0; k < 60; k++) begin
            set_all(8'hFF);
            if ($urandom_range(0, 2) == 0) in[$urandom_range(0, 7)][$urandom_range(0, 7)] = 1'b0;
            rst = ($urandom_range(0, 15) == 0);
            tick("rand_mix");
        end
        rst = 0;

        for (int i = 0; i < 8; i++) cin[i] = 4'hF;
        #1;
        chk("comb_all_ones", cq, 4'h1);
        for (int i = 0; i < 8; i++) begin
            for (int b = 0; b < 4; b++) begin
                cin[i][b] = 1'b0;
                #1;
                chk("comb_one_zero", cq, 4'h0);
                cin[i][b] = 1'b1;
            end
        end
        #1;
        chk("comb_restored", cq, 4'h1);
`ifdef TOP_MODULE_HIT_MASK_EN
        cin[2] = 4'h0;
        #1;
        chk("comb_hit_mask", chm, 8'hFB);
        chk("comb_c_zero", cq, 4'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/top_module_reduce_and.md
Name: top_module_reduce_and

Overview:
- Eight-input, WIDTH-bit wide AND-reduction block with a registered output pipeline.
- q[0] is 1 only when every bit of inputs a..h is 1; all upper bits of q are always 0.
- Used as an "all lanes saturated / all-ones" detector feeding downstream control logic.

Parameters:
- Port_Num, default 2: number of output register stages (latency in clk cycles). Legal range 0..8; 0 means purely combinational. Declared first, so positional override order is (Port_Num, WIDTH).
- WIDTH, default 8: bit width of each input a..h and of output q. Must be >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- a  input  WIDTH  operand 0.
- b  input  WIDTH  operand 1.
- c  input  WIDTH  operand 2.
- d  input  WIDTH  operand 3.
- e  input  WIDTH  operand 4.
- f  input  WIDTH  operand 5.
- g  input  WIDTH  operand 6.
- h  input  WIDTH  operand 7.
- q  output  WIDTH  q[0] = AND of all 8*WIDTH input bits, delayed Port_Num cycles; q[WIDTH-1:1] = 0.
- One clock; reset is synchronous and active-high (clk, rst).

Behaviour:
- Combinational core: r = &{a,b,c,d,e,f,g,h} (1 bit); zero-extend r to WIDTH bits.
- Any single 0 bit in any input forces r = 0.
- Per-input reductions (&a .. &h) are computed first and then ANDed; the result is identical to a flat 8*WIDTH reduction.
- Pipeline: Port_Num register stages. The value on q at cycle t+Port_Num equals the core result for the inputs sampled at edge t.
- Fully pipelined: a new operand set is accepted every cycle, with no stalls and no handshake.
- Port_Num = 0: q follows the inputs combinationally; rst has no effect on q.
- Reset: while rst = 1 at a clk edge, every pipeline stage loads 0, so q = 0 from the next edge on.
- Reset mid-operation: results in flight are discarded. After rst deasserts, q stays 0 until a post-reset input has propagated Port_Num stages.
- Before the first clk edge, q is don't-care. The bench applies rst before checking.
- Upper bits q[WIDTH-1:1] are constant 0 in every stage. They need no flops.
- No X-propagation masking: an X on any input bit propagates to q[0] per standard Verilog & semantics.

Optional Feature:
- Macro TOP_MODULE_HIT_MASK_EN.
- When defined: adds output port hit_mask [7:0]. hit_mask[i] = 1 when input i (a=bit0 .. h=bit7) is all-ones.
- hit_mask is pipelined through the same Port_Num stages as q and is cleared by rst, so it is aligned cycle-for-cycle with q.
- Invariant: q[0] == &hit_mask.
- When not defined: the port and its registers do not exist, and q behaviour is unchanged.

Test Plan (WIDTH=8, Port_Num=2 unless noted):
- rst=1 for 2 cycles with all inputs 0xFF -> q=0x00 throughout reset and 1 cycle after. Then q=0x01 on the 2nd edge after rst drops.
- All inputs 0xFF except h=0xFE -> q=0x00 two cycles later. Repeat with a=0x7F and with d=0xEF -> q=0x00 each time.
- 10 cycles of random inputs in 0..127 (MSB clear) -> q=0x00 every cycle, compared against a 2-cycle-delayed model.
- Alternate per cycle between all-0xFF and all-0x00 -> q toggles 0x01/0x00 with exactly 2-cycle latency and no dropped results.
- Drive all-0xFF, assert rst for 1 cycle one edge later -> the in-flight 1 never appears on q; q returns to 0x01 only 2 edges after rst deasserts.
- Port_Num=0, WIDTH=4, all inputs 0xF -> q=0x1 immediately. Set any one bit to 0 -> q=0x0 with no clock. With TOP_MODULE_HIT_MASK_EN and only c=0x0 -> hit_mask=0xFB.
